xor_arbiter: RTL and testbench

XOR_ARBITER -- requirements
Module: xor_arbiter

---
 rtl/xor_arbiter.sv | 129 ++++++++++++
 tb/tb_xor_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/xor_arbiter.sv
// Two-requester round-robin arbiter in front of a shared XOR unit.
// Each transaction runs IDLE -> CALC (LAT cycles) -> DONE -> IDLE.
module xor_arbiter #(
   parameter int WIDTH = 8,
   parameter int LAT   = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0,
   input  logic [WIDTH-1:0] i_a0,
   input  logic [WIDTH-1:0] i_b0,
   output logic             o_gnt0,
   output logic             o_done0,
   input  logic             i_req1,
   input  logic [WIDTH-1:0] i_a1,
   input  logic [WIDTH-1:0] i_b1,
   output logic             o_gnt1,
   output logic             o_done1,
   output logic [WIDTH-1:0] o_f,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter counts down to zero; the CALC cycle seeing zero is the last.
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ptr_q, ptr_d;
   logic             sel_q, sel_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] f_q, f_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             win1;

   // Requester 1 wins when alone, or when both ask and the pointer favours it.
   assign win1 = i_req1 & (~i_req0 | ptr_q);

   // Next-state, capture and pulse generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      a_d     = a_q;
      b_d     = b_q;
      f_d     = f_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_req0 | i_req1) begin
               sel_d   = win1;
               a_d     = win1 ? i_a1 : i_a0;
               b_d     = win1 ? i_b1 : i_b0;
               cnt_d   = CNT_INIT;
               gnt0_d  = ~win1;
               gnt1_d  = win1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (cnt_q == 4'd0) begin
               f_d     = a_q ^ b_q;
               done0_d = ~sel_q;
               done1_d = sel_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            ptr_d   = ~sel_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset overrides everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
         sel_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
      end
   end

   assign o_gnt0  = gnt0_q;
   assign o_gnt1  = gnt1_q;
   assign o_done0 = done0_q;
   assign o_done1 = done1_q;
   assign o_f     = f_q;
   assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed vector bench for xor_arbiter (WIDTH=8, LAT=2).
// Each vector's inputs are sampled at one edge; outputs checked just after.
module tb_xor_arbiter;

   logic       clk = 1'b0;
   logic       rst, req0, req1;
   logic [7:0] a0, b0, a1, b1;
   logic       gnt0, gnt1, done0, done1, busy;
   logic [7:0] f;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xor_arbiter #(.WIDTH(8), .LAT(2)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req0  (req0),
      .i_a0    (a0),
      .i_b0    (b0),
      .o_gnt0  (gnt0),
      .o_done0 (done0),
      .i_req1  (req1),
      .i_a1    (a1),
      .i_b1    (b1),
      .o_gnt1  (gnt1),
      .o_done1 (done1),
      .o_f     (f),
      .o_busy  (busy)
   );

   typedef struct {
      logic       rst, r0, r1;
      logic [7:0] a0, b0, a1, b1;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(
      input logic rs, input logic r0,
      input logic [7:0] xa0, input logic [7:0] xb0,
      input logic r1,
      input logic [7:0] xa1, input logic [7:0] xb1,
      input logic g0, input logic g1,
      input logic d0, input logic d1,
      input logic bz, input logic [7:0] ef);
      vec_t t;
      t.rst = rs; t.r0 = r0; t.r1 = r1;
      t.a0 = xa0; t.b0 = xb0; t.a1 = xa1; t.b1 = xb1;
      t.exp = {g0, g1, d0, d1, bz, ef};
      return t;
   endfunction

   task automatic drive(input vec_t t);
      @(negedge clk);
      rst = t.rst; req0 = t.r0; req1 = t.r1;
      a0 = t.a0; b0 = t.b0; a1 = t.a1; b1 = t.b1;
   endtask

   task automatic check(input string nm, input logic [12:0] exp);
      logic [12:0] got;
      @(posedge clk);
      #1;
      got = {gnt0, gnt1, done0, done1, busy, f};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got g0g1d0d1bz=%b f=%h want g0g1d0d1bz=%b f=%h",
                  nm, got[12:8], got[7:0], exp[12:8], exp[7:0]);
      end
   endtask

   initial begin
      logic [7:0] fx, x, y;
      int who, ph;
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;

      // reset, then single request 0
      tbl.push_back(v(1,0,8'h00,8'h00,0,8'h00,8'h00, 0,0,0,0,0,8'h00));
      tbl.push_back(v(0,1,8'hA5,8'h0F,0,8'h00,8'h00, 1,0,0,0,1,8'h00));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h00,8'h00, 0,0,0,0,1,8'h00));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h00,8'h00, 0,0,1,0,1,8'hAA));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h00,8'h00, 0,0,0,0,0,8'hAA));
      // 1-bit truth table through requester 1
      fx = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         x = {7'd0, i[1]};
         y = {7'd0, i[0]};
         tbl.push_back(v(0,0,8'h00,8'h00,1,x,y, 0,1,0,0,1,fx));
         tbl.push_back(v(0,0,8'h00,8'h00,0,x,y, 0,0,0,0,1,fx));
         fx = (i == 1 || i == 2) ? 8'h01 : 8'h00;
         tbl.push_back(v(0,0,8'h00,8'h00,0,x,y, 0,0,0,1,1,fx));
         tbl.push_back(v(0,0,8'h00,8'h00,0,x,y, 0,0,0,0,0,fx));
      end
      // req1 pulsed during requester 0's CALC is withdrawn
      tbl.push_back(v(0,1,8'h3C,8'hC3,0,8'h00,8'h00, 1,0,0,0,1,8'h00));
      tbl.push_back(v(0,0,8'h3C,8'hC3,1,8'h55,8'h55, 0,0,0,0,1,8'h00));
      tbl.push_back(v(0,0,8'h3C,8'hC3,0,8'h55,8'h55, 0,0,1,0,1,8'hFF));
      tbl.push_back(v(0,0,8'h3C,8'hC3,0,8'h55,8'h55, 0,0,0,0,0,8'hFF));
      tbl.push_back(v(0,0,8'h3C,8'hC3,0,8'h55,8'h55, 0,0,0,0,0,8'hFF));
      // operand change after capture
      tbl.push_back(v(0,1,8'hFF,8'h0F,0,8'h00,8'h00, 1,0,0,0,1,8'hFF));
      tbl.push_back(v(0,0,8'h00,8'h0F,0,8'h00,8'h00, 0,0,0,0,1,8'hFF));
      tbl.push_back(v(0,0,8'h00,8'h0F,0,8'h00,8'h00, 0,0,1,0,1,8'hF0));
      tbl.push_back(v(0,0,8'h00,8'h0F,0,8'h00,8'h00, 0,0,0,0,0,8'hF0));
      // reset in the last CALC cycle aborts the transaction
      tbl.push_back(v(0,1,8'hA5,8'h0F,0,8'h00,8'h00, 1,0,0,0,1,8'hF0));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h00,8'h00, 0,0,0,0,1,8'hF0));
      tbl.push_back(v(1,0,8'hA5,8'h0F,0,8'h00,8'h00, 0,0,0,0,0,8'h00));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h00,8'h00, 0,0,0,0,0,8'h00));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h00,8'h00, 0,0,0,0,0,8'h00));
      // reset beats a request; first edge after reset is normal IDLE
      tbl.push_back(v(1,1,8'hA5,8'h0F,1,8'h0F,8'hF0, 0,0,0,0,0,8'h00));
      tbl.push_back(v(0,0,8'hA5,8'h0F,1,8'h0F,8'hF0, 0,1,0,0,1,8'h00));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h0F,8'hF0, 0,0,0,0,1,8'h00));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h0F,8'hF0, 0,0,0,1,1,8'hFF));
      tbl.push_back(v(0,0,8'hA5,8'h0F,0,8'h0F,8'hF0, 0,0,0,0,0,8'hFF));

      foreach (tbl[i]) begin
         drive(tbl[i]);
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Both requests held from reset: alternate 0,1,0,1 every LAT+2 cycles
      drive(v(1,0,8'h11,8'h00,0,8'h22,8'h00, 0,0,0,0,0,8'h00));
      check("rr_reset", 13'd0);
      @(negedge clk);
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
      fx = 8'h00;
      for (int n = 0; n < 16; n++) begin
         who = (n / 4) % 2;
         ph  = n % 4;
         if (ph == 2) fx = (who == 1) ? 8'h22 : 8'h11;
         check($sformatf("rr%0d", n),
               {ph == 0 && who == 0, ph == 0 && who == 1,
                ph == 2 && who == 0, ph == 2 && who == 1,
                ph != 3, fx});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
